dco_loop_filter: RTL and testbench
==================================

# dco_loop_filter

Digital PI loop filter that sits directly upstream of the DCO row/column decoder in the DPLL frequency-lock block. It accepts signed phase/frequency error samples from the detector and integrates them with saturation and anti-windup. It then drives the 8-bit binary tuning word `s_mtrx` that the decoder converts to the 16x16 thermometer matrix. It also reports a lock indication.

## Interface
- `ERR_W`, 8: width of the signed error input.
- `KP_SHIFT`, 1: proportional gain is 2^-KP_SHIFT code LSB per error LSB.
- `KI_SHIFT`, 4: integral gain is 2^-KI_SHIFT code LSB per error LSB per sample.
- `ACC_FRAC`, 6: fractional bits of the integrator. Must satisfy ACC_FRAC >= KI_SHIFT and ACC_FRAC >= KP_SHIFT.
- `LOCK_WIN`, 2: lock window; |err| <= LOCK_WIN counts as in-window.
- `LOCK_CNT`, 16: number of consecutive in-window samples required to declare lock.
- `clk`  in  1  single clock. All logic is rising-edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `en`  in  1  loop enable. When 0, samples are ignored and the outputs are held.
- `err_valid`  in  1  qualifies `err`. Back-to-back every cycle is allowed.
- `err`  in  ERR_W  signed two's-complement error.
- `load_init`  in  1  single-cycle request to preset the code.
- `code_init`  in  8  preset value used by `load_init`.
- `s_mtrx`  out  8  registered tuning word to the decoder.
- `code_valid`  out  1  one-cycle pulse when `s_mtrx` is updated from a sample.
- `sat_hi` / `sat_lo`  out  1  set when the last computed output clipped to 255 / 0.
- `locked`  out  1  lock indication.

## Operation
- FSM states:
  - IDLE: entered while en=0.
  - TRACK: entered when en=1.
  - LOCKED: entered from TRACK once the lock counter reaches LOCK_CNT; returns to TRACK on any out-of-window sample.
  - Any state goes to IDLE when en=0.
- Integrator I:
  - Signed, width 8+ACC_FRAC+2 bits, in units of 2^-ACC_FRAC code LSB.
  - Reset value: 128<<ACC_FRAC.
- Stage 1, on an accepted sample (en=1, err_valid=1, load_init=0):
  - I <= clamp(I + (err <<< (ACC_FRAC-KI_SHIFT)), 0, (255<<ACC_FRAC) + 2^ACC_FRAC - 1). The clamp is the anti-windup.
  - P_r <= err <<< (ACC_FRAC-KP_SHIFT).
  - valid1 <= 1.
- Stage 2, when valid1=1:
  - sum = I + P_r, using the already-updated I.
  - s_mtrx <= sat((sum >>> ACC_FRAC), 0, 255). The shift is arithmetic, truncating toward minus infinity.
  - sat_hi/sat_lo are updated; code_valid pulses.
- `load_init`:
  - Has priority over `err_valid` in the same cycle; that sample is discarded.
  - Flushes valid1, sets I <= code_init<<ACC_FRAC and s_mtrx <= code_init.
  - Clears sat_hi, sat_lo and the lock counter; no code_valid pulse.
  - Honoured even when en=0.
- en=0:
  - Clears valid1, so an in-flight sample is dropped.
  - Holds I and s_mtrx.
  - Clears the lock counter and `locked`.

## Timing
- Reset values (async, on rst_n=0): s_mtrx=128, I=128<<ACC_FRAC, valid1=0, code_valid=0, sat_hi=0, sat_lo=0, locked=0, lock counter=0, state=IDLE.
- Latency: a sample accepted at edge k updates s_mtrx and raises code_valid at edge k+1. Throughput is one sample per cycle.
- `load_init` sampled at edge k: s_mtrx=code_init after edge k.
- `locked` changes at the same edge as the code_valid of the deciding sample.
- Reset asserted mid-operation: all outputs return to their reset values immediately, without waiting for clk.

## Configuration
- `DCO_LOOP_LOCK_DET_EN` defined:
  - Lock counter, LOCKED state and `locked` output are implemented.
  - |err| <= LOCK_WIN increments the counter (saturating at LOCK_CNT).
  - An out-of-window sample clears the counter and drops `locked`.
- Undefined:
  - No counter and no LOCKED state; the FSM has IDLE and TRACK only.
  - `locked` is tied to 0.
  - Filter behaviour is identical.

## Test plan
All scenarios use default parameters.
- Reset: hold rst_n=0 -> s_mtrx=128, code_valid=0, sat_hi=0, sat_lo=0, locked=0. Assert rst_n mid-stream -> s_mtrx=128 with no clock edge.
- Step response: en=1, one sample err=+16 -> s_mtrx=137 with a code_valid pulse one edge later. Next sample err=0 -> s_mtrx=129.
- High saturation: 40 samples err=+127 -> s_mtrx=255, sat_hi=1, I=16383. Then err=-1 -> s_mtrx=255. Then err=-127 -> s_mtrx=184, sat_hi=0 (no windup).
- Preset: load_init=1 with code_init=40 in the same cycle as err_valid=1, err=+100 -> s_mtrx=40 after that edge, no code_valid pulse, and the sample is ignored. Low clip: then err=-128 -> s_mtrx=0, sat_lo=1.
- Lock (macro defined): 16 consecutive samples with err in {-2,0,2} -> locked=1 on the 16th code_valid. Next err=3 -> locked=0. Toggling en=0 also clears locked.
- Back-to-back and enable: err=+8 on 4 consecutive cycles -> four code_valid pulses, s_mtrx 132,133,133,134. A sample with en=0 -> no pulse and s_mtrx unchanged.

Source files
------------

// File: rtl/dco_loop_filter.sv
// dco_loop_filter: PI loop filter driving the DCO tuning word s_mtrx.
// Optional lock detector enabled by defining DCO_LOOP_LOCK_DET_EN.
module dco_loop_filter #(
   parameter int ERR_W    = 8,
   parameter int KP_SHIFT = 1,
   parameter int KI_SHIFT = 4,
   parameter int ACC_FRAC = 6,
   parameter int LOCK_WIN = 2,
   parameter int LOCK_CNT = 16
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             err_valid,
   input  logic [ERR_W-1:0] err,
   input  logic             load_init,
   input  logic [7:0]       code_init,
   output logic [7:0]       s_mtrx,
   output logic             code_valid,
   output logic             sat_hi,
   output logic             sat_lo,
   output logic             locked
);

   localparam int IW = 8 + ACC_FRAC + 2;
   localparam int SW = IW + 1;

   localparam logic signed [IW-1:0] I_RST    = IW'(128 << ACC_FRAC);
   localparam logic signed [SW-1:0] I_MAX    = SW'((256 << ACC_FRAC) - 1);
   localparam logic signed [SW-1:0] CODE_MAX = SW'(255);

   localparam logic [1:0] S_IDLE   = 2'd0;
   localparam logic [1:0] S_TRACK  = 2'd1;
   localparam logic [1:0] S_LOCKED = 2'd2;

   logic signed [IW-1:0] i_q, i_d;
   logic signed [SW-1:0] p_q, p_d;
   logic                 valid1_q, valid1_d;
   logic [7:0]           code_q, code_d;
   logic                 cv_q, cv_d;
   logic                 shi_q, shi_d;
   logic                 slo_q, slo_d;
   logic [1:0]           st_q, st_d;

   logic signed [SW-1:0] err_x;
   logic signed [SW-1:0] i_ext;
   logic signed [SW-1:0] i_sum;
   logic signed [SW-1:0] sum;
   logic signed [SW-1:0] q;
   logic                 stage2;

   assign err_x  = $signed({{(SW-ERR_W){err[ERR_W-1]}}, err});
   assign i_ext  = $signed({i_q[IW-1], i_q});
   assign i_sum  = i_ext + (err_x <<< (ACC_FRAC - KI_SHIFT));
   assign sum    = i_ext + p_q;
   assign q      = sum >>> ACC_FRAC;
   assign stage2 = valid1_q && (st_q != S_IDLE);

   // Filter datapath: integrate with anti-windup, then saturate the code.
   always_comb begin
      i_d      = i_q;
      p_d      = p_q;
      valid1_d = 1'b0;
      code_d   = code_q;
      cv_d     = 1'b0;
      shi_d    = shi_q;
      slo_d    = slo_q;
      if (load_init) begin
         i_d    = $signed({2'b00, code_init, {ACC_FRAC{1'b0}}});
         code_d = code_init;
         shi_d  = 1'b0;
         slo_d  = 1'b0;
      end else if (en) begin
         if (stage2) begin
            cv_d = 1'b1;
            if (sum[SW-1]) begin
               code_d = 8'd0;
               shi_d  = 1'b0;
               slo_d  = 1'b1;
            end else if (q > CODE_MAX) begin
               code_d = 8'd255;
               shi_d  = 1'b1;
               slo_d  = 1'b0;
            end else begin
               code_d = q[7:0];
               shi_d  = 1'b0;
               slo_d  = 1'b0;
            end
         end
         if (err_valid) begin
            valid1_d = 1'b1;
            p_d      = err_x <<< (ACC_FRAC - KP_SHIFT);
            if (i_sum[SW-1])
               i_d = '0;
            else if (i_sum > I_MAX)
               i_d = I_MAX[IW-1:0];
            else
               i_d = i_sum[IW-1:0];
         end
      end
   end

`ifdef DCO_LOOP_LOCK_DET_EN
   localparam int CW = $clog2(LOCK_CNT + 1);
   localparam logic [CW-1:0]        CNT_MAX = CW'(LOCK_CNT);
   localparam logic signed [SW-1:0] WIN_P   = SW'(LOCK_WIN);
   localparam logic signed [SW-1:0] WIN_N   = -WIN_P;

   logic [CW-1:0] cnt_q, cnt_d;
   logic          win_q, win_d;
   logic          in_win;

   assign in_win = (err_x >= WIN_N) && (err_x <= WIN_P);

   // Lock FSM: count in-window samples as their codes are issued.
   always_comb begin
      st_d  = st_q;
      cnt_d = cnt_q;
      win_d = win_q;
      if (!en) begin
         st_d  = S_IDLE;
         cnt_d = '0;
      end else begin
         if (st_q == S_IDLE)
            st_d = S_TRACK;
         if (load_init) begin
            // a preset restarts acquisition, so lock must be re-earned
            cnt_d = '0;
            st_d  = S_TRACK;
         end else begin
            if (err_valid)
               win_d = in_win;
            if (stage2) begin
               if (win_q) begin
                  if (cnt_q != CNT_MAX)
                     cnt_d = cnt_q + CW'(1);
                  if (cnt_d == CNT_MAX)
                     st_d = S_LOCKED;
               end else begin
                  cnt_d = '0;
                  st_d  = S_TRACK;
               end
            end
         end
      end
   end

   // Lock counter and window flag registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         cnt_q <= '0;
         win_q <= 1'b0;
      end else begin
         cnt_q <= cnt_d;
         win_q <= win_d;
      end
   end

   assign locked = (st_q == S_LOCKED);
`else
   // Enable-only FSM when lock detection is not built.
   always_comb begin
      st_d = en ? S_TRACK : S_IDLE;
   end

   assign locked = 1'b0;
`endif

   // Pipeline, integrator and output registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         i_q      <= I_RST;
         p_q      <= '0;
         valid1_q <= 1'b0;
         code_q   <= 8'd128;
         cv_q     <= 1'b0;
         shi_q    <= 1'b0;
         slo_q    <= 1'b0;
         st_q     <= S_IDLE;
      end else begin
         i_q      <= i_d;
         p_q      <= p_d;
         valid1_q <= valid1_d;
         code_q   <= code_d;
         cv_q     <= cv_d;
         shi_q    <= shi_d;
         slo_q    <= slo_d;
         st_q     <= st_d;
      end
   end

   assign s_mtrx     = code_q;
   assign code_valid = cv_q;
   assign sat_hi     = shi_q;
   assign sat_lo     = slo_q;

endmodule

// File: tb/tb_dco_loop_filter.sv
// tb_dco_loop_filter: directed bench with a sample-level model of the filter.
// Lock checks follow DCO_LOOP_LOCK_DET_EN when it is defined.
module tb_dco_loop_filter;

   logic       clk = 1'b0;
   logic       rst_n = 1'b0;
   logic       en = 1'b0;
   logic       err_valid = 1'b0;
   logic [7:0] err = '0;
   logic       load_init = 1'b0;
   logic [7:0] code_init = '0;
   logic [7:0] s_mtrx;
   logic       code_valid;
   logic       sat_hi;
   logic       sat_lo;
   logic       locked;

`ifdef DCO_LOOP_LOCK_DET_EN
   localparam bit LD = 1'b1;
`else
   localparam bit LD = 1'b0;
`endif

   int checks = 0;
   int errors = 0;

   dco_loop_filter dut (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (en),
      .err_valid  (err_valid),
      .err        (err),
      .load_init  (load_init),
      .code_init  (code_init),
      .s_mtrx     (s_mtrx),
      .code_valid (code_valid),
      .sat_hi     (sat_hi),
      .sat_lo     (sat_lo),
      .locked     (locked)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act,
                      input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
      end
   endtask

   // Model state: integrator in 1/64 code units, plus the result of a
   // sample that has been accepted but not yet shown on the outputs.
   int m_i, m_code, m_cv, m_hi, m_lo, m_cnt, m_lock;
   int p_pend, p_out, p_hi, p_lo, p_win;

   function automatic int fdiv64(input int x);
      return (x >= 0) ? x / 64 : -((-x + 63) / 64);
   endfunction

   function automatic void model_reset();
      m_i = 128 * 64;
      m_code = 128;
      m_cv = 0; m_hi = 0; m_lo = 0;
      m_cnt = 0; m_lock = 0;
      p_pend = 0;
   endfunction

   function automatic void model_step(input int s_en, input int s_v,
                                      input int s_e, input int s_ld,
                                      input int s_init);
      int total, qv;
      m_cv = 0;
      if (s_ld != 0) begin
         m_i = s_init * 64;
         m_code = s_init;
         m_hi = 0; m_lo = 0;
         p_pend = 0; m_cnt = 0; m_lock = 0;
      end else if (s_en == 0) begin
         p_pend = 0; m_cnt = 0; m_lock = 0;
      end else begin
         if (p_pend != 0) begin
            m_code = p_out; m_hi = p_hi; m_lo = p_lo; m_cv = 1;
            if (p_win != 0) m_cnt = (m_cnt < 16) ? m_cnt + 1 : 16;
            else m_cnt = 0;
            m_lock = (m_cnt == 16) ? 1 : 0;
         end
         p_pend = 0;
         if (s_v != 0) begin
            m_i = m_i + s_e * 4;
            if (m_i < 0) m_i = 0;
            if (m_i > 16383) m_i = 16383;
            total = m_i + s_e * 32;
            qv = fdiv64(total);
            p_hi = (qv > 255) ? 1 : 0;
            p_lo = (qv < 0) ? 1 : 0;
            p_out = (qv > 255) ? 255 : (qv < 0) ? 0 : qv;
            p_win = (s_e >= -2 && s_e <= 2) ? 1 : 0;
            p_pend = 1;
         end
      end
   endfunction

   // Compare process: advance the model on each edge and check all outputs.
   initial begin
      int s_en, s_v, s_e, s_ld, s_init, s_rst;
      model_reset();
      forever begin
         @(posedge clk);
         s_en = int'(en); s_v = int'(err_valid);
         s_e = int'($signed(err)); s_ld = int'(load_init);
         s_init = int'(code_init); s_rst = int'(rst_n);
         #1;
         if (s_rst == 0) model_reset();
         else model_step(s_en, s_v, s_e, s_ld, s_init);
         chk("cmp_s_mtrx", 32'(s_mtrx), 32'(m_code));
         chk("cmp_code_valid", 32'(code_valid), 32'(m_cv));
         chk("cmp_sat_hi", 32'(sat_hi), 32'(m_hi));
         chk("cmp_sat_lo", 32'(sat_lo), 32'(m_lo));
         chk("cmp_locked", 32'(locked), LD ? 32'(m_lock) : 32'd0);
      end
   end

   task automatic drive(input bit e_n, input bit v, input int e,
                        input bit ld = 1'b0, input int init = 0);
      en = e_n; err_valid = v; err = 8'(e);
      load_init = ld; code_init = 8'(init);
      @(posedge clk);
      #2;
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      en = 1'b0; err_valid = 1'b0; load_init = 1'b0;
      @(posedge clk);
      #2;
      rst_n = 1'b1;
   endtask

   initial begin
      int wv[3];
      wv[0] = -2; wv[1] = 0; wv[2] = 2;
      repeat (3) @(posedge clk);
      #2;
      chk("rst_s_mtrx", 32'(s_mtrx), 32'd128);
      chk("rst_code_valid", 32'(code_valid), 32'd0);
      chk("rst_sat_hi", 32'(sat_hi), 32'd0);
      chk("rst_sat_lo", 32'(sat_lo), 32'd0);
      chk("rst_locked", 32'(locked), 32'd0);
      rst_n = 1'b1;

      // step response
      drive(1, 1, 16);
      drive(1, 1, 0);
      chk("step_137", 32'(s_mtrx), 32'd137);
      chk("step_cv", 32'(code_valid), 32'd1);
      drive(1, 0, 0);
      chk("step_129", 32'(s_mtrx), 32'd129);
      drive(1, 0, 0);
      chk("step_cv_off", 32'(code_valid), 32'd0);

      // high saturation and anti-windup
      repeat (40) drive(1, 1, 127);
      chk("model_I_max", 32'(m_i), 32'd16383);
      drive(1, 1, -1);
      chk("sat_255", 32'(s_mtrx), 32'd255);
      chk("sat_hi_set", 32'(sat_hi), 32'd1);
      drive(1, 1, -127);
      chk("sat_m1_255", 32'(s_mtrx), 32'd255);
      drive(1, 0, 0);
      chk("unwind_184", 32'(s_mtrx), 32'd184);
      chk("unwind_hi0", 32'(sat_hi), 32'd0);

      // asynchronous reset mid-stream
      #1;
      rst_n = 1'b0;
      #1;
      chk("async_rst_s_mtrx", 32'(s_mtrx), 32'd128);
      chk("async_rst_cv", 32'(code_valid), 32'd0);
      @(posedge clk);
      #2;
      rst_n = 1'b1;

      // preset beats a same-cycle sample, then low clip
      drive(1, 1, 100, 1'b1, 40);
      chk("preset_40", 32'(s_mtrx), 32'd40);
      chk("preset_no_cv", 32'(code_valid), 32'd0);
      drive(1, 1, -128);
      chk("preset_hold", 32'(s_mtrx), 32'd40);
      chk("preset_dropped", 32'(code_valid), 32'd0);
      drive(1, 0, 0);
      chk("clip_0", 32'(s_mtrx), 32'd0);
      chk("sat_lo_set", 32'(sat_lo), 32'd1);

      // back-to-back samples and enable gating
      do_reset();
      drive(1, 1, 8);
      drive(1, 1, 8);
      chk("b2b_132", 32'(s_mtrx), 32'd132);
      drive(1, 1, 8);
      chk("b2b_133a", 32'(s_mtrx), 32'd133);
      drive(1, 1, 8);
      chk("b2b_133b", 32'(s_mtrx), 32'd133);
      drive(1, 0, 0);
      chk("b2b_134", 32'(s_mtrx), 32'd134);
      drive(1, 1, 50);
      drive(0, 1, 50);
      chk("en0_hold", 32'(s_mtrx), 32'd134);
      chk("en0_no_cv", 32'(code_valid), 32'd0);
      drive(0, 0, 0);
      chk("en0_hold2", 32'(s_mtrx), 32'd134);

      // lock acquisition, loss and enable clear
      do_reset();
      for (int i = 0; i < 16; i++) drive(1, 1, wv[i % 3]);
      chk("lock_15_not_yet", 32'(locked), 32'd0);
      drive(1, 1, 3);
      chk("lock_16", 32'(locked), 32'(LD));
      drive(1, 0, 0);
      chk("lock_lost", 32'(locked), 32'd0);
      for (int i = 0; i < 16; i++) drive(1, 1, wv[i % 3]);
      drive(1, 0, 0);
      chk("relock", 32'(locked), 32'(LD));
      drive(0, 0, 0);
      chk("en0_unlock", 32'(locked), 32'd0);

      drive(0, 0, 0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
